// File: rtl/pll_phase_stepper_if.sv
// Request channel between a shift requester (master) and the PLL phase stepper (slave).
// A request is accepted on any cycle where req_valid and req_ready are both high.
interface pll_phase_stepper_if #(
  parameter int unsigned CNTSEL_W = 5,
  parameter int unsigned STEP_W   = 8
) ();
  logic                req_valid;
  logic                req_ready;
  logic [CNTSEL_W-1:0] req_cntsel;
  logic                req_updn;
  logic [STEP_W-1:0]   req_steps;

  modport master (
    output req_valid,
    output req_cntsel,
    output req_updn,
    output req_steps,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_cntsel,
    input  req_updn,
    input  req_steps,
    output req_ready
  );
endinterface

// File: rtl/pll_phase_stepper.sv
// Sequences dynamic PLL phase shifts: sets up cntsel/updn, pulses phase_en per step and
// waits on the phase_done handshake, with lock-loss and timeout detection.
module pll_phase_stepper #(
  parameter int unsigned CNTSEL_W  = 5,
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned EN_HOLD   = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                scanclk,
  input  logic                rst,
  pll_phase_stepper_if.slave  req,
  input  logic                pll_locked,
  input  logic                pll_phase_done,
  output logic                pll_phase_en,
  output logic [CNTSEL_W-1:0] pll_cntsel,
  output logic                pll_updn,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err,
  output logic [STEP_W-1:0]   steps_done
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitLock,
    StSetup,
    StPulse,
    StWaitDone,
    StRecover,
    StFinish
  } state_e;

  // One shared timer covers SETUP, PULSE and WAIT_DONE, so size it for the largest.
  localparam int unsigned TmrW = $clog2(TIMEOUT + SETUP_CYC + EN_HOLD + 1);

  localparam logic [1:0]        ErrNone    = 2'b00;
  localparam logic [1:0]        ErrTimeout = 2'b01;
  localparam logic [1:0]        ErrLock    = 2'b10;
  localparam logic [STEP_W-1:0] StepsMax   = '1;

  state_e              state_q, state_d;
  logic [TmrW-1:0]     timer_q, timer_d;
  logic [CNTSEL_W-1:0] cntsel_q, cntsel_d;
  logic                updn_q, updn_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [STEP_W-1:0]   steps_done_q, steps_done_d;
  logic [1:0]          err_q, err_d;
  logic [CNTSEL_W-1:0] pll_cntsel_q, pll_cntsel_d;
  logic                pll_updn_q, pll_updn_d;
  logic                phase_en_q, phase_en_d;
  logic                done_q, done_d;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cntsel_d     = cntsel_q;
    updn_d       = updn_q;
    steps_d      = steps_q;
    steps_done_d = steps_done_q;
    err_d        = err_q;
    pll_cntsel_d = pll_cntsel_q;
    pll_updn_d   = pll_updn_q;

    unique case (state_q)
      StIdle: begin
        if (req.req_valid) begin
          cntsel_d     = req.req_cntsel;
          updn_d       = req.req_updn;
          steps_d      = req.req_steps;
          err_d        = ErrNone;
          steps_done_d = '0;
          state_d      = StWaitLock;
        end
      end
      StWaitLock: begin
        if (pll_locked) begin
          timer_d = '0;
          if (steps_q == '0) begin
            state_d = StFinish;
          end else begin
            pll_cntsel_d = cntsel_q;
            pll_updn_d   = updn_q;
            state_d      = StSetup;
          end
        end
      end
      StSetup: begin
        if (timer_q == TmrW'(SETUP_CYC - 1)) begin
          timer_d = '0;
          state_d = StPulse;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StPulse: begin
        if (timer_q == TmrW'(EN_HOLD - 1)) begin
          timer_d = '0;
          state_d = StWaitDone;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StWaitDone: begin
        if (!pll_phase_done) begin
          if (steps_done_q != StepsMax) begin
            steps_done_d = steps_done_q + STEP_W'(1);
          end
          timer_d = '0;
          state_d = StRecover;
        end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
          err_d   = ErrTimeout;
          timer_d = '0;
          state_d = StFinish;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StRecover: begin
        if (pll_phase_done) begin
          timer_d = '0;
          state_d = (steps_done_q < steps_q) ? StPulse : StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Lock loss overrides whatever the step sequencing decided this cycle.
    if (!pll_locked && (state_q inside {StSetup, StPulse, StWaitDone, StRecover})) begin
      steps_done_d = steps_done_q;
      err_d        = ErrLock;
      timer_d      = '0;
      state_d      = StFinish;
    end

    phase_en_d = (state_d == StPulse);
    done_d     = (state_d == StFinish) && (err_d == ErrNone);
  end

  always_ff @(posedge scanclk) begin
    if (rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      cntsel_q     <= '0;
      updn_q       <= 1'b0;
      steps_q      <= '0;
      steps_done_q <= '0;
      err_q        <= ErrNone;
      pll_cntsel_q <= '0;
      pll_updn_q   <= 1'b0;
      phase_en_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cntsel_q     <= cntsel_d;
      updn_q       <= updn_d;
      steps_q      <= steps_d;
      steps_done_q <= steps_done_d;
      err_q        <= err_d;
      pll_cntsel_q <= pll_cntsel_d;
      pll_updn_q   <= pll_updn_d;
      phase_en_q   <= phase_en_d;
      done_q       <= done_d;
    end
  end

  assign req.req_ready = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign pll_phase_en  = phase_en_q;
  assign pll_cntsel    = pll_cntsel_q;
  assign pll_updn      = pll_updn_q;
  assign done          = done_q;
  assign err           = err_q;
  assign steps_done    = steps_done_q;

endmodule

// File: doc/pll_phase_stepper.md
PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

Interface
REQ-001 SHALL have parameter CNTSEL_W, default 5, width of the PLL counter-select bus.
REQ-002 SHALL have parameter STEP_W, default 8, width of the step-count request field.
REQ-003 SHALL have parameter SETUP_CYC, default 2, cycles cntsel/updn are held stable before phase_en rises (minimum 1).
REQ-004 SHALL have parameter EN_HOLD, default 2, cycles phase_en is held high per step (minimum 2).
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum WAIT_DONE cycles before an error.
REQ-006 SHALL have port scanclk  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port req_valid  in  1  shift request present.
REQ-009 SHALL have port req_ready  out  1  high only in IDLE.
REQ-010 SHALL have port req_cntsel  in  CNTSEL_W  target PLL counter.
REQ-011 SHALL have port req_updn  in  1  1 = positive shift, 0 = negative.
REQ-012 SHALL have port req_steps  in  STEP_W  number of phase steps; 0 = no-op.
REQ-013 SHALL have port pll_locked  in  1  PLL lock indicator.
REQ-014 SHALL have port pll_phase_done  in  1  PLL handshake; low = step complete.
REQ-015 SHALL have port pll_phase_en  out  1  to PLL.
REQ-016 SHALL have ports pll_cntsel  out  CNTSEL_W and pll_updn  out  1  to PLL, both registered.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.
REQ-018 SHALL have port done  out  1  one-cycle pulse on successful completion.
REQ-019 SHALL have port err  out  2  sticky until next accepted request: 00 none, 01 timeout, 10 lock lost.
REQ-020 SHALL have port steps_done  out  STEP_W  count of completed steps in the current or last request.

Function
REQ-021 SHALL implement states IDLE, WAIT_LOCK, SETUP, PULSE, WAIT_DONE, RECOVER, FINISH.
REQ-022 IDLE: on req_valid=1, SHALL capture cntsel, updn and steps, clear err and steps_done, and go to WAIT_LOCK next cycle.
REQ-023 WAIT_LOCK: SHALL stay while pll_locked=0 with no timeout; when pll_locked=1, SHALL go to FINISH if steps=0, else to SETUP.
REQ-024 SETUP: SHALL drive captured cntsel/updn onto pll_cntsel/pll_updn for exactly SETUP_CYC cycles with pll_phase_en=0, then go to PULSE.
REQ-025 PULSE: SHALL hold pll_phase_en=1 for exactly EN_HOLD cycles, then go to WAIT_DONE with pll_phase_en=0.
REQ-026 WAIT_DONE: on pll_phase_done=0, SHALL increment steps_done and go to RECOVER; after TIMEOUT cycles without it, SHALL set err=01 and go to FINISH.
REQ-027 RECOVER: SHALL wait for pll_phase_done=1, then go to PULSE if steps_done<steps, else to FINISH; pll_cntsel/pll_updn SHALL stay stable across steps.
REQ-028 FINISH: SHALL assert done for one cycle only if err=00, then return to IDLE; done SHALL NOT assert on error.
REQ-029 In SETUP, PULSE, WAIT_DONE or RECOVER, pll_locked=0 SHALL set err=10, force pll_phase_en=0 the next cycle, and go to FINISH; lock loss SHALL win over a same-cycle phase_done.
REQ-030 req_valid outside IDLE SHALL be ignored; no queuing.
REQ-031 steps_done SHALL saturate at 2^STEP_W-1 and never wrap; req_steps=2^STEP_W-1 SHALL run to completion.
REQ-032 pll_phase_en SHALL never be high outside PULSE.

Reset
REQ-033 rst=1 SHALL force IDLE, pll_phase_en=0, pll_cntsel=0, pll_updn=0, busy=0, done=0, err=00, steps_done=0, timers cleared.
REQ-034 rst asserted mid-operation, including during PULSE, SHALL drop pll_phase_en on the next edge and discard the request.

Verification
REQ-035 Locked PLL, req cntsel=1, updn=1, steps=3, PLL model pulls phase_done low 4 cycles after each phase_en fall -> three EN_HOLD-wide phase_en pulses, steps_done=3, one done pulse, err=00.
REQ-036 steps=0 with pll_locked=1 -> no phase_en activity, done pulses, steps_done=0.
REQ-037 pll_locked=0 for 50 cycles after request -> busy, no phase_en; lock rises -> sequence starts, SETUP lasts exactly SETUP_CYC cycles.
REQ-038 steps=2, PLL model never lowers phase_done -> err=01 after TIMEOUT cycles in WAIT_DONE, steps_done=0, no done pulse.
REQ-039 pll_locked falls during second of 4 steps -> err=10, pll_phase_en=0 next cycle, steps_done=1, return to IDLE.
REQ-040 rst pulsed while pll_phase_en=1, and req_valid pulsed while busy -> outputs return to reset values next edge; the busy-time request is never executed.
